// File: rtl/filtro_solicitud_pkg.sv
// -----------------------------------------------------------------------------
// filtro_solicitud_pkg
// Shared definitions for the request conditioning stage: FSM state encoding,
// reset polarity and the counter width helper. Every file of the block imports
// this package so the encodings are defined in one place.
// -----------------------------------------------------------------------------
package filtro_solicitud_pkg;

  // Reset is active-low: the design resets when reset equals this value.
  localparam logic RESET_ACTIVO = 1'b0;

  // Conditioning FSM states. Encodings 5..7 are unused and recover to BAJO.
  typedef enum logic [2:0] {
    BAJO        = 3'd0,
    VALIDA_ALTO = 3'd1,
    ALTO        = 3'd2,
    VALIDA_BAJO = 3'd3,
    BLOQUEO     = 3'd4
  } estado_t;

  // The same counter times both the stability window and the lockout.
  // It must therefore hold the larger of the two limits. With the default
  // parameters this is $clog2(N_ESTABLE+1).
  function automatic int ancho_cnt(input int n_estable, input int min_bajo);
    int mayor;
    mayor = (n_estable > min_bajo) ? n_estable : min_bajo;
    return $clog2(mayor + 1);
  endfunction

endpackage

// File: rtl/filtro_solicitud_sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
// Two-flop synchroniser for a single asynchronous level input. It is reusable
// for any sensor line. Both flops clear on a synchronous, active-low reset.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-low reset
//   d     - asynchronous input
//   q     - input re-timed to clk (two cycles of latency)
// -----------------------------------------------------------------------------
module sincronizador
  import filtro_solicitud_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s_sync_q;

  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVO) begin
      s1_q     <= 1'b0;
      s_sync_q <= 1'b0;
    end else begin
      s1_q     <= d;
      s_sync_q <= s1_q;
    end
  end

  assign q = s_sync_q;

endmodule

// File: rtl/filtro_solicitud.sv
// -----------------------------------------------------------------------------
// filtro_solicitud
// Conditions the raw request sensor line for the fill/discharge controller.
// The line is synchronised and then debounced with a stability counter. After
// every release, R is held low for a minimum time. This guarantees that the
// controller returns to its initial state before it sees a new request.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-low reset
//   s_in   - raw sensor request, asynchronous to clk
//   R      - debounced, registered request
//   subida - one-cycle pulse in the first cycle R=1
//   bajada - one-cycle pulse in the first cycle R=0 after a release
// -----------------------------------------------------------------------------
module filtro_solicitud
  import filtro_solicitud_pkg::*;
#(
  parameter int N_ESTABLE = 4,
  parameter int MIN_BAJO  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic s_in,
  output logic R,
  output logic subida,
  output logic bajada
);

  localparam int CNT_W = ancho_cnt(N_ESTABLE, MIN_BAJO);
  localparam logic [CNT_W-1:0] CNT_UNO      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ESTABLE  = CNT_W'(N_ESTABLE - 1);
  localparam logic [CNT_W-1:0] CNT_BLOQUEO  = CNT_W'(MIN_BAJO - 1);

  logic             s_sync;
  estado_t          state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             r_q,      r_d;
  logic             subida_q, subida_d;
  logic             bajada_q, bajada_d;

  sincronizador u_sincronizador (
    .clk   (clk),
    .reset (reset),
    .d     (s_in),
    .q     (s_sync)
  );

  // Next-state logic. The state entered counts as the first stable sample,
  // so a validation state starts with cnt=1. When cnt reaches N_ESTABLE-1,
  // the next equal sample is the N_ESTABLE-th and it commits the change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BAJO: begin
        if (s_sync) begin
          state_d = VALIDA_ALTO;
          cnt_d   = CNT_UNO;
        end
      end
      VALIDA_ALTO: begin
        if (!s_sync) begin
          state_d = BAJO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ESTABLE) begin
          state_d = ALTO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_UNO;
        end
      end
      ALTO: begin
        if (!s_sync) begin
          state_d = VALIDA_BAJO;
          cnt_d   = CNT_UNO;
        end
      end
      VALIDA_BAJO: begin
        if (s_sync) begin
          state_d = ALTO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ESTABLE) begin
          state_d = BLOQUEO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_UNO;
        end
      end
      BLOQUEO: begin
        // The input is ignored here. This stretches the low time so the
        // controller always completes its return to idle.
        if (cnt_q == CNT_BLOQUEO) begin
          state_d = BAJO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_UNO;
        end
      end
      default: begin
        state_d = BAJO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they change on the same
  // edge as the state. The pulses come only from committed transitions.
  // A bounce back from VALIDA_BAJO to ALTO therefore does not fire subida.
  always_comb begin
    r_d      = (state_d == ALTO) || (state_d == VALIDA_BAJO);
    subida_d = (state_q == VALIDA_ALTO) && (state_d == ALTO);
    bajada_d = (state_q == VALIDA_BAJO) && (state_d == BLOQUEO);
  end

  // A reset forces R low without a bajada pulse, even when R was high.
  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVO) begin
      state_q  <= BAJO;
      cnt_q    <= '0;
      r_q      <= 1'b0;
      subida_q <= 1'b0;
      bajada_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      subida_q <= subida_d;
      bajada_q <= bajada_d;
    end
  end

  assign R      = r_q;
  assign subida = subida_q;
  assign bajada = bajada_q;

endmodule
